// File: rtl/spec_streamer_pkg.sv
// Shared types and helpers for the spectrum streamer: reader states and lane arithmetic.
package spec_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } rd_state_t;

    localparam int HDR_BEATS = 1;

    function automatic int lanes(input int in_width, input int out_width);
        return in_width / out_width;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spec_streamer_if.sv
// AXI-Stream style beat channel (data, valid, ready, last) between streamer and consumer.
interface spec_streamer_if #(
    parameter int OUT_WIDTH = 32
);
    logic [OUT_WIDTH-1:0] tdata;
    logic                 tvalid;
    logic                 tready;
    logic                 tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dpram.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of registered latency.
module dpram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic                  en_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] dout_b
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    always_ff @(posedge clk) begin
        if (en_b) begin
            dout_b <= mem[addr_b];
        end
    end
endmodule

// File: rtl/spec_streamer_skid2.sv
// Two-entry output FIFO; its occupancy is exported so the reader only issues reads it can absorb.
module axis_skid2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             pop;

    assign valid = (count_reg != 2'd0);
    assign data  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign pop   = valid && ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/spec_streamer.sv
// Captures accumulated spectra into a ping-pong RAM and streams each one as a header beat
// followed by every word split into lanes, tolerating arbitrary downstream backpressure.
module spec_streamer
    import spec_streamer_pkg::*;
#(
    parameter int VECTOR_WIDTH = 11,
    parameter int IN_WIDTH     = 128,
    parameter int OUT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [IN_WIDTH-1:0]     in_data,
    input  logic                    in_we,
    input  logic [VECTOR_WIDTH-1:0] in_addr,
    spec_streamer_if.master         m,
    output logic [31:0]             frame_count,
    output logic [15:0]             drop_count,
    output logic                    busy
);
    localparam int LANES  = lanes(IN_WIDTH, OUT_WIDTH);
    localparam int LANE_W = idx_width(LANES);
    localparam logic [VECTOR_WIDTH-1:0] LAST      = '1;
    localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(LANES - 1);

    rd_state_t               state_reg, state_next;
    logic                    wr_bank_reg, rd_bank_reg;
    logic [VECTOR_WIDTH-1:0] addr_reg;
    logic [LANE_W-1:0]       lane_reg;
    logic                    issued_all_reg;
    logic                    pipe_valid_reg, pipe_hdr_reg, pipe_last_reg;
    logic [LANE_W-1:0]       pipe_lane_reg;
    logic [31:0]             frame_count_reg;
    logic [15:0]             drop_count_reg;

    logic                    wr_en, frame_end, accept, drop;
    logic                    pop, reader_done, credit_ok;
    logic                    issue, rd_en, is_last_beat;
    logic [2:0]              occupancy;
    logic [1:0]              fifo_count;
    logic                    fifo_valid;
    logic [OUT_WIDTH:0]      fifo_data, push_data;
    logic [IN_WIDTH-1:0]     rd_word;
    logic [OUT_WIDTH-1:0]    lane_words [LANES];

    assign wr_en     = ce && in_we;
    assign frame_end = wr_en && (in_addr == LAST);

    assign pop         = fifo_valid && m.tready;
    assign reader_done = (state_reg == DATA) && pop && fifo_data[OUT_WIDTH];
    assign accept      = frame_end && ((state_reg == IDLE) || reader_done);
    assign drop        = frame_end && !accept;

    // Beats already queued or in flight through the RAM, net of the one leaving this cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, pipe_valid_reg} - {2'b00, pop};
    assign credit_ok = (occupancy < 3'd2);

    assign is_last_beat = (state_reg == DATA) && (addr_reg == LAST) && (lane_reg == LAST_LANE);

    // ---------------- reader FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept) state_next = HEADER;
            HEADER:  if (issue) state_next = DATA;
            DATA:    if (reader_done) state_next = accept ? HEADER : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        rd_en = 1'b0;
        unique case (state_reg)
            HEADER: issue = credit_ok;
            DATA: begin
                issue = credit_ok && !issued_all_reg;
                rd_en = credit_ok && !issued_all_reg;
            end
            default: ;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // ---------------- banks, counters, read walk ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_reg     <= 1'b0;
            rd_bank_reg     <= 1'b0;
            frame_count_reg <= 32'd0;
            drop_count_reg  <= 16'd0;
            addr_reg        <= '0;
            lane_reg        <= '0;
            issued_all_reg  <= 1'b0;
            pipe_valid_reg  <= 1'b0;
            pipe_hdr_reg    <= 1'b0;
            pipe_last_reg   <= 1'b0;
            pipe_lane_reg   <= '0;
        end else begin
            if (accept) begin
                rd_bank_reg     <= wr_bank_reg;
                wr_bank_reg     <= ~wr_bank_reg;
                frame_count_reg <= frame_count_reg + 32'd1;
            end
            if (drop && (drop_count_reg != 16'hFFFF)) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end

            pipe_valid_reg <= issue;
            pipe_hdr_reg   <= (state_reg == HEADER);
            pipe_last_reg  <= is_last_beat;
            pipe_lane_reg  <= lane_reg;

            if (accept) begin
                addr_reg       <= '0;
                lane_reg       <= '0;
                issued_all_reg <= 1'b0;
            end else if (rd_en) begin
                if (is_last_beat) issued_all_reg <= 1'b1;
                if (lane_reg == LAST_LANE) begin
                    lane_reg <= '0;
                    addr_reg <= addr_reg + 1'b1;
                end else begin
                    lane_reg <= lane_reg + 1'b1;
                end
            end
        end
    end

    assign frame_count = frame_count_reg;
    assign drop_count  = drop_count_reg;

    // ---------------- storage and lane mux ----------------
    dpram #(
        .ADDR_WIDTH (VECTOR_WIDTH + 1),
        .DATA_WIDTH (IN_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we_a   (wr_en),
        .addr_a ({wr_bank_reg, in_addr}),
        .din_a  (in_data),
        .en_b   (rd_en),
        .addr_b ({rd_bank_reg, addr_reg}),
        .dout_b (rd_word)
    );

    // Each lane re-reads the same word, so the RAM output always matches the beat in the pipe.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_words[gi] = rd_word[gi*OUT_WIDTH +: OUT_WIDTH];
    end

    assign push_data = pipe_hdr_reg ? {1'b0, OUT_WIDTH'(frame_count_reg)}
                                    : {pipe_last_reg, lane_words[pipe_lane_reg]};

    axis_skid2 #(
        .WIDTH (OUT_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid_reg),
        .push_data (push_data),
        .ready     (m.tready),
        .valid     (fifo_valid),
        .data      (fifo_data),
        .count     (fifo_count)
    );

    assign m.tvalid = fifo_valid;
    assign m.tdata  = fifo_data[OUT_WIDTH-1:0];
    assign m.tlast  = fifo_data[OUT_WIDTH];

endmodule

// File: tb/tb_spec_streamer.sv
// Directed bench for spec_streamer with an 8-bin spectrum (33 beats per frame).
module tb_spec_streamer;
    localparam int VW = 3;
    localparam int IW = 128;
    localparam int OW = 32;
    localparam int NBEATS = 33;

    logic          clk = 1'b0;
    logic          rst, ce, in_we;
    logic [IW-1:0] in_data;
    logic [VW-1:0] in_addr;
    logic [31:0]   frame_count;
    logic [15:0]   drop_count;
    logic          busy;

    spec_streamer_if #(.OUT_WIDTH(OW)) m ();

    spec_streamer #(.VECTOR_WIDTH(VW), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .in_data     (in_data),
        .in_we       (in_we),
        .in_addr     (in_addr),
        .m           (m),
        .frame_count (frame_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] bq_data [$];
    logic        bq_last [$];
    int          bq_cyc  [$];

    function automatic logic [31:0] exp_lane(input logic [7:0] tag, input logic [7:0] addr,
                                             input logic [7:0] lane);
        return {tag, 8'h00, addr, lane};
    endfunction

    // Expected beat i of a frame: header, then addr-major / lane-minor words; bin 7 may carry tag7.
    function automatic logic [31:0] exp_beat(input logic [7:0] tag, input logic [7:0] tag7,
                                             input logic [31:0] hdr, input int i);
        int k;
        if (i == 0) return hdr;
        k = i - 1;
        return exp_lane(((k / 4) == 7) ? tag7 : tag, 8'(k / 4), 8'(k % 4));
    endfunction

    function automatic logic [IW-1:0] make_word(input logic [7:0] tag, input int bin);
        logic [IW-1:0] w;
        for (int l = 0; l < 4; l++) w[l*32 +: 32] = exp_lane(tag, 8'(bin), 8'(l));
        return w;
    endfunction

    // Record a beat if it handshakes at the coming edge, then advance one cycle.
    task automatic tick();
        if (m.tvalid && m.tready) begin
            bq_data.push_back(m.tdata);
            bq_last.push_back(m.tlast);
            bq_cyc.push_back(cyc);
            $display("beat cyc=%0d data=%08h last=%0b", cyc, m.tdata, m.tlast);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_q();
        bq_data.delete();
        bq_last.delete();
        bq_cyc.delete();
    endtask

    task automatic write_bin(input logic [7:0] tag, input int bin, input logic ce_val);
        ce = ce_val;
        in_we = 1'b1;
        in_addr = 3'(bin);
        in_data = make_word(tag, bin);
        tick();
        in_we = 1'b0;
        ce = 1'b1;
    endtask

    task automatic write_frame(input logic [7:0] tag, output int fe_cyc);
        for (int b = 0; b < 8; b++) write_bin(tag, b, 1'b1);
        fe_cyc = cyc;
    endtask

    task automatic drain(input int budget, output bit timed_out);
        bit got_last;
        timed_out = 1'b1;
        for (int n = 0; n < budget; n++) begin
            m.tready = 1'b1;
            got_last = m.tvalid && m.tlast;
            tick();
            if (got_last) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce = 1'b1;
        in_we = 1'b0;
        in_addr = '0;
        in_data = '0;
        m.tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_q();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m.tvalid); end
        checks++; if (m.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m.tlast); end
        checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_frame();
        int fe;
        bit to;
        clear_q();
        m.tready = 1'b1;
        write_frame(8'h11, fe);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (m.tvalid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", m.tvalid); end
        drain(200, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout got timeout want tlast"); end
        checks++; if (bq_data.size() != NBEATS) begin errors++; $display("FAIL single_beats got %0d want %0d", bq_data.size(), NBEATS); end
        if (bq_data.size() == NBEATS) begin
            checks++; if (bq_cyc[0] != fe + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", bq_cyc[0] - fe, 2); end
            for (int i = 0; i < NBEATS; i++) begin
                checks++;
                if (bq_data[i] !== exp_beat(8'h11, 8'h11, 32'd1, i) || bq_last[i] !== (i == NBEATS - 1)
                    || bq_cyc[i] != bq_cyc[0] + i) begin
                    errors++;
                    $display("FAIL single_beat%0d got %08h/%b@%0d want %08h/%b@%0d", i, bq_data[i], bq_last[i],
                             bq_cyc[i], exp_beat(8'h11, 8'h11, 32'd1, i), (i == NBEATS - 1), bq_cyc[0] + i);
                end
            end
        end
        checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL single_frame_count got %0d want 1", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int fe;
        bit prev_stall, got_last, done;
        logic [31:0] pd;
        logic pl;
        clear_q();
        m.tready = 1'b0;
        write_frame(8'h22, fe);
        prev_stall = 1'b0;
        done = 1'b0;
        pd = '0;
        pl = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (prev_stall) begin
                checks++;
                if (m.tvalid !== 1'b1 || m.tdata !== pd || m.tlast !== pl) begin
                    errors++;
                    $display("FAIL stall_hold got %b/%08h/%b want 1/%08h/%b", m.tvalid, m.tdata, m.tlast, pd, pl);
                end
            end
            m.tready = 1'($urandom_range(0, 1));
            prev_stall = m.tvalid && !m.tready;
            pd = m.tdata;
            pl = m.tlast;
            got_last = m.tvalid && m.tready && m.tlast;
            tick();
            if (got_last) begin
                done = 1'b1;
                break;
            end
        end
        m.tready = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL bp_timeout got timeout want tlast"); end
        checks++; if (bq_data.size() != NBEATS) begin errors++; $display("FAIL bp_beats got %0d want %0d", bq_data.size(), NBEATS); end
        if (bq_data.size() == NBEATS) begin
            for (int i = 0; i < NBEATS; i++) begin
                checks++;
                if (bq_data[i] !== exp_beat(8'h22, 8'h22, 32'd2, i) || bq_last[i] !== (i == NBEATS - 1)) begin
                    errors++;
                    $display("FAIL bp_beat%0d got %08h/%b want %08h/%b", i, bq_data[i], bq_last[i],
                             exp_beat(8'h22, 8'h22, 32'd2, i), (i == NBEATS - 1));
                end
            end
        end
    endtask

    task automatic test_overrun();
        int fe;
        bit to;
        do_reset();
        write_frame(8'h31, fe);
        tick(); tick(); tick();
        checks++; if (m.tvalid !== 1'b1) begin errors++; $display("FAIL ovr_header_wait got %b want 1", m.tvalid); end
        write_frame(8'h32, fe);
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovr_drop got %0d want 1", drop_count); end
        checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL ovr_frames got %0d want 1", frame_count); end
        drain(200, to);
        checks++; if (to || bq_data.size() != NBEATS) begin errors++; $display("FAIL ovr_first_beats got %0d want %0d", bq_data.size(), NBEATS); end
        for (int i = 0; i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[i] !== exp_beat(8'h31, 8'h31, 32'd1, i)) begin
                errors++; $display("FAIL ovr_first_beat%0d got %08h want %08h", i, bq_data[i], exp_beat(8'h31, 8'h31, 32'd1, i));
            end
        end
        clear_q();
        write_frame(8'h33, fe);
        drain(200, to);
        checks++; if (to || bq_data.size() != NBEATS) begin errors++; $display("FAIL ovr_third_beats got %0d want %0d", bq_data.size(), NBEATS); end
        for (int i = 0; i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[i] !== exp_beat(8'h33, 8'h33, 32'd2, i) || bq_last[i] !== (i == NBEATS - 1)) begin
                errors++; $display("FAIL ovr_third_beat%0d got %08h want %08h", i, bq_data[i], exp_beat(8'h33, 8'h33, 32'd2, i));
            end
        end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovr_drop_after got %0d want 1", drop_count); end
    endtask

    task automatic test_back_to_back();
        int fe, fe2, nlast;
        bit sent;
        logic [7:0] tg;
        logic [31:0] hd;
        clear_q();
        m.tready = 1'b1;
        write_frame(8'h41, fe);
        nlast = 0;
        sent = 1'b0;
        fe2 = 0;
        for (int n = 0; n < 300; n++) begin
            in_we = 1'b0;
            if (n < 7) begin
                in_we = 1'b1; in_addr = 3'(n); in_data = make_word(8'h42, n);
            end else if (!sent && m.tvalid && m.tlast) begin
                in_we = 1'b1; in_addr = 3'd7; in_data = make_word(8'h42, 7);
                sent = 1'b1; fe2 = cyc + 1;
            end
            if (m.tvalid && m.tready && m.tlast) nlast++;
            tick();
            if (nlast == 2) break;
        end
        in_we = 1'b0;
        checks++; if (!sent || nlast != 2) begin errors++; $display("FAIL b2b_frames got %0d lasts want 2", nlast); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL b2b_drop got %0d want 1", drop_count); end
        checks++; if (frame_count !== 32'd4) begin errors++; $display("FAIL b2b_frame_count got %0d want 4", frame_count); end
        checks++; if (bq_data.size() != 2 * NBEATS) begin errors++; $display("FAIL b2b_beats got %0d want %0d", bq_data.size(), 2 * NBEATS); end
        if (bq_data.size() == 2 * NBEATS) begin
            checks++; if (bq_cyc[NBEATS] != fe2 + 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", bq_cyc[NBEATS] - fe2); end
            for (int i = 0; i < 2 * NBEATS; i++) begin
                tg = (i < NBEATS) ? 8'h41 : 8'h42;
                hd = (i < NBEATS) ? 32'd3 : 32'd4;
                checks++;
                if (bq_data[i] !== exp_beat(tg, tg, hd, i % NBEATS) || bq_last[i] !== ((i % NBEATS) == NBEATS - 1)) begin
                    errors++; $display("FAIL b2b_beat%0d got %08h want %08h", i, bq_data[i], exp_beat(tg, tg, hd, i % NBEATS));
                end
            end
        end
    endtask

    task automatic test_ce_gating();
        int fe;
        bit to;
        m.tready = 1'b1;
        write_frame(8'h51, fe);
        drain(200, to);
        clear_q();
        write_frame(8'h52, fe);
        for (int b = 0; b < 8; b++) write_bin(8'h5F, b, 1'b0);
        checks++; if (frame_count !== 32'd6) begin errors++; $display("FAIL ce_frame_count got %0d want 6", frame_count); end
        drain(200, to);
        checks++; if (to || bq_data.size() != NBEATS) begin errors++; $display("FAIL ce_stream_beats got %0d want %0d", bq_data.size(), NBEATS); end
        for (int i = 0; i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[i] !== exp_beat(8'h52, 8'h52, 32'd6, i) || bq_last[i] !== (i == NBEATS - 1)) begin
                errors++; $display("FAIL ce_stream_beat%0d got %08h want %08h", i, bq_data[i], exp_beat(8'h52, 8'h52, 32'd6, i));
            end
        end
        checks++; if (drop_count !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL ce_idle got drop=%0d busy=%b want 1/0", drop_count, busy); end
        clear_q();
        write_bin(8'h53, 7, 1'b1);
        drain(200, to);
        checks++; if (to || bq_data.size() != NBEATS) begin errors++; $display("FAIL ce_keep_beats got %0d want %0d", bq_data.size(), NBEATS); end
        for (int i = 0; i < bq_data.size(); i++) begin
            checks++;
            if (bq_data[i] !== exp_beat(8'h51, 8'h53, 32'd7, i)) begin
                errors++; $display("FAIL ce_keep_beat%0d got %08h want %08h", i, bq_data[i], exp_beat(8'h51, 8'h53, 32'd7, i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int fe;
        bit to;
        clear_q();
        m.tready = 1'b1;
        write_frame(8'h61, fe);
        for (int b = 0; b < 4; b++) write_bin(8'h6A, b, 1'b1);
        repeat (8) tick();
        checks++; if (busy !== 1'b1 || m.tvalid !== 1'b1) begin errors++; $display("FAIL mid_precond got busy=%b valid=%b want 1/1", busy, m.tvalid); end
        rst = 1'b1;
        tick();
        checks++; if (m.tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b want 0", m.tvalid); end
        checks++; if (frame_count !== 32'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL mid_counters got %0d/%0d want 0/0", frame_count, drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        rst = 1'b0;
        clear_q();
        write_frame(8'h62, fe);
        drain(200, to);
        checks++; if (to || bq_data.size() != NBEATS) begin errors++; $display("FAIL mid_beats got %0d want %0d", bq_data.size(), NBEATS); end
        if (bq_data.size() == NBEATS) begin
            checks++; if (bq_cyc[0] != fe + 2) begin errors++; $display("FAIL mid_latency got %0d want 2", bq_cyc[0] - fe); end
            for (int i = 0; i < NBEATS; i++) begin
                checks++;
                if (bq_data[i] !== exp_beat(8'h62, 8'h62, 32'd1, i) || bq_last[i] !== (i == NBEATS - 1)) begin
                    errors++; $display("FAIL mid_beat%0d got %08h want %08h", i, bq_data[i], exp_beat(8'h62, 8'h62, 32'd1, i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_ce_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
